// File: rtl/eeg_pkg.sv
// Shared constants and helpers for the EEG pad bridge.
package eeg_pkg;

    localparam int unsigned PAD_DW_DEF = 8;
    localparam int unsigned RATIO_DEF  = 4;
    localparam int unsigned DEPTH_DEF  = 4;

    // Ceiling log2, used for pointer and counter widths.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        while ((64'd1 << r) < 64'(v)) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/eeg_sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers (log2(DEPTH)+1 bits).
// Full/empty come from the MSB and address compare; contents clear on reset.
module eeg_sync_fifo
    import eeg_pkg::*;
#(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic [W-1:0] rdata,
    output logic         full,
    output logic         empty
);

    localparam int unsigned AW = clog2(DEPTH);

    logic [AW:0]  wptr;
    logic [AW:0]  rptr;
    logic [W-1:0] mem [DEPTH];

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
    assign rdata = mem[rptr[AW-1:0]];

    // Storage and pointer update; push ignored when full, pop ignored when empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push && !full) begin
                mem[wptr[AW-1:0]] <= wdata;
                wptr              <= wptr + (AW+1)'(1);
            end
            if (pop && !empty) begin
                rptr <= rptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/eeg_pad_bridge.sv
// Pad <-> accelerator width bridge: packs RATIO pad beats into one word on the
// way in and splits result words back into pad beats on the way out.
// Optional feature: define EEG_PAD_BRIDGE_STAT_EN to enable STAT_CNT counters.
module eeg_pad_bridge
    import eeg_pkg::*;
#(
    parameter int unsigned PAD_DW = PAD_DW_DEF,
    parameter int unsigned RATIO  = RATIO_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     PAD_DAT_VLD,
    input  logic                     PAD_DAT_LST,
    output logic                     PAD_DAT_RDY,
    input  logic [PAD_DW-1:0]        PAD_DAT_DAT,
    input  logic                     PAD_DAT_CMD,
    output logic                     ACC_DAT_VLD,
    output logic                     ACC_DAT_LST,
    input  logic                     ACC_DAT_RDY,
    output logic [PAD_DW*RATIO-1:0]  ACC_DAT_DAT,
    output logic                     ACC_DAT_CMD,
    input  logic                     ACC_OUT_VLD,
    input  logic                     ACC_OUT_LST,
    output logic                     ACC_OUT_RDY,
    input  logic [PAD_DW*RATIO-1:0]  ACC_OUT_DAT,
    output logic                     PAD_OUT_VLD,
    output logic                     PAD_OUT_LST,
    input  logic                     PAD_OUT_RDY,
    output logic [PAD_DW-1:0]        PAD_OUT_DAT,
    output logic [31:0]              STAT_CNT
);

    localparam int unsigned ACC_DW = PAD_DW * RATIO;
    localparam int unsigned LW     = clog2(RATIO);
    localparam logic [LW-1:0] LAST_LANE = LW'(RATIO - 1);

    logic              rdy_en;
    logic [LW-1:0]     lane;
    logic [ACC_DW-1:0] acc_r;
    logic              cmd_r;
    logic [ACC_DW-1:0] pk_word;
    logic              pk_cmd;
    logic              pk_close;
    logic              beat_acc;
    logic              in_push;
    logic              in_full;
    logic              in_empty;
    logic [ACC_DW+1:0] in_head;

    logic [LW-1:0]     beat;
    logic              out_full;
    logic              out_empty;
    logic              out_pop;
    logic [ACC_DW:0]   out_head;

    // RDY outputs stay low in reset and rise on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
        end
    end

    assign PAD_DAT_RDY = rdy_en && !in_full;
    assign ACC_OUT_RDY = rdy_en && !out_full;
    assign beat_acc    = PAD_DAT_VLD && PAD_DAT_RDY;
    assign in_push     = beat_acc && pk_close;

    // Word under assembly: captured lanes plus the current beat; upper lanes stay zero.
    always_comb begin
        pk_word = acc_r;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (lane == LW'(i)) begin
                pk_word[i*PAD_DW +: PAD_DW] = PAD_DAT_DAT;
            end
        end
        pk_cmd   = (lane == '0) ? PAD_DAT_CMD : cmd_r;
        pk_close = (lane == LAST_LANE) || PAD_DAT_LST;
    end

    // Packer lane counter and partial-word register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lane  <= '0;
            acc_r <= '0;
            cmd_r <= 1'b0;
        end else if (beat_acc) begin
            if (lane == '0) begin
                cmd_r <= PAD_DAT_CMD;
            end
            if (pk_close) begin
                lane  <= '0;
                acc_r <= '0;
            end else begin
                lane  <= lane + LW'(1);
                acc_r <= pk_word;
            end
        end
    end

    eeg_sync_fifo #(
        .W     (ACC_DW + 2),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_push),
        .wdata ({PAD_DAT_LST, pk_cmd, pk_word}),
        .pop   (ACC_DAT_VLD && ACC_DAT_RDY),
        .rdata (in_head),
        .full  (in_full),
        .empty (in_empty)
    );

    assign ACC_DAT_VLD = !in_empty;
    assign ACC_DAT_LST = in_head[ACC_DW+1];
    assign ACC_DAT_CMD = in_head[ACC_DW];
    assign ACC_DAT_DAT = in_head[ACC_DW-1:0];

    eeg_sync_fifo #(
        .W     (ACC_DW + 1),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (ACC_OUT_VLD && ACC_OUT_RDY),
        .wdata ({ACC_OUT_LST, ACC_OUT_DAT}),
        .pop   (out_pop),
        .rdata (out_head),
        .full  (out_full),
        .empty (out_empty)
    );

    assign PAD_OUT_VLD = !out_empty;
    assign PAD_OUT_LST = out_head[ACC_DW] && (beat == LAST_LANE);
    assign out_pop     = PAD_OUT_VLD && PAD_OUT_RDY && (beat == LAST_LANE);

    // Lane select of the head result word for the current beat.
    always_comb begin
        PAD_OUT_DAT = '0;
        for (int unsigned i = 0; i < RATIO; i++) begin
            if (beat == LW'(i)) begin
                PAD_OUT_DAT = out_head[i*PAD_DW +: PAD_DW];
            end
        end
    end

    // Unpacker beat counter, wraps to 0 as the head word pops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat <= '0;
        end else if (PAD_OUT_VLD && PAD_OUT_RDY) begin
            beat <= (beat == LAST_LANE) ? '0 : beat + LW'(1);
        end
    end

`ifdef EEG_PAD_BRIDGE_STAT_EN
    logic [15:0] in_cnt;
    logic [15:0] out_cnt;

    // Saturating counts of words accepted on ACC_DAT and ACC_OUT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt  <= '0;
            out_cnt <= '0;
        end else begin
            if (ACC_DAT_VLD && ACC_DAT_RDY && (in_cnt != '1)) begin
                in_cnt <= in_cnt + 16'd1;
            end
            if (ACC_OUT_VLD && ACC_OUT_RDY && (out_cnt != '1)) begin
                out_cnt <= out_cnt + 16'd1;
            end
        end
    end

    assign STAT_CNT = {out_cnt, in_cnt};
`else
    assign STAT_CNT = '0;
`endif

endmodule
